// File: rtl/ahb_picomem_responder.sv
// ahb_picomem_responder: AHB-Lite single-transfer slave bridged onto a PicoRV32 native memory port,
// with byte-lane steering, size/offset strobe generation and two-cycle ERROR on illegal transfers.
`default_nettype none

module ahb_picomem_responder #(
  parameter bit BIG_ENDIAN_AHB = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR1   = 2'd2,
    S_ERR2   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        instr_q;
  logic [31:0] hrdata_q;

  logic        accept;
  logic        legal;
  logic [3:0]  strb;
  logic        unused_ok;

  // Full byte reversal is its own inverse, so one function serves both directions.
  function automatic logic [31:0] map_lanes(input logic [31:0] d);
    if (BIG_ENDIAN_AHB) map_lanes = {d[7:0], d[15:8], d[23:16], d[31:24]};
    else                map_lanes = d;
  endfunction

  assign unused_ok = ^{htrans[0], hprot[3:1]};

  always_comb begin
    legal = 1'b1;
    if (hsize > 3'd2)                             legal = 1'b0;
    else if (hsize == 3'd1 && haddr[0])           legal = 1'b0;
    else if (hsize == 3'd2 && haddr[1:0] != 2'b00) legal = 1'b0;
  end

  // ERR2 drives hreadyout=1, so it is a valid address-phase slot just like IDLE.
  assign accept = hsel && hready && htrans[1] && (state_q == S_IDLE || state_q == S_ERR2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (accept) state_d = legal ? S_ACCESS : S_ERR1;
        else        state_d = S_IDLE;
      end
      S_ACCESS: if (mem_ready) state_d = S_IDLE;
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      instr_q  <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
        size_q  <= hsize[1:0];
        instr_q <= ~hprot[0];
      end
      if (state_q == S_ACCESS && mem_ready && !write_q)
        hrdata_q <= map_lanes(mem_rdata);
    end
  end

  always_comb begin
    strb = 4'b0000;
    case (size_q)
      2'd0:    strb = 4'b0001 << addr_q[1:0];
      2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  assign hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign hrdata    = hrdata_q;
  assign mem_valid = (state_q == S_ACCESS);
  assign mem_instr = instr_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wstrb = write_q ? strb : 4'b0000;
  // hwdata is held by the master while hreadyout=0, so no capture register is needed.
  assign mem_wdata = map_lanes(hwdata);

endmodule

`default_nettype wire

// File: tb/tb_ahb_picomem_responder.sv
// Directed bench for ahb_picomem_responder: big-endian and little-endian instances share one AHB stimulus.
`default_nettype none

module tb_ahb_picomem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        be_hreadyout, be_hresp, be_mem_valid, be_mem_instr;
  logic [31:0] be_hrdata, be_mem_addr, be_mem_wdata;
  logic [3:0]  be_mem_wstrb;
  logic        le_hreadyout, le_hresp, le_mem_valid, le_mem_instr;
  logic [31:0] le_hrdata, le_mem_addr, le_mem_wdata;
  logic [3:0]  le_mem_wstrb;

  int errors = 0;
  int checks = 0;
  int low_cnt;

  always #5 clk = ~clk;
  assign hready = be_hreadyout;

  ahb_picomem_responder #(.BIG_ENDIAN_AHB(1'b1)) u_be (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(be_hreadyout), .hresp(be_hresp), .hrdata(be_hrdata),
    .mem_valid(be_mem_valid), .mem_instr(be_mem_instr), .mem_ready(mem_ready),
    .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata), .mem_wstrb(be_mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  ahb_picomem_responder #(.BIG_ENDIAN_AHB(1'b0)) u_le (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready),
    .hreadyout(le_hreadyout), .hresp(le_hresp), .hrdata(le_hrdata),
    .mem_valid(le_mem_valid), .mem_instr(le_mem_instr), .mem_ready(mem_ready),
    .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata), .mem_wstrb(le_mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase for a single cycle, leaving the bus idle afterwards.
  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                            input logic [3:0] prot);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hprot = prot;
    tick();
    hsel = 1'b0; htrans = 2'b00;
  endtask

  initial begin
    resetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd0; hprot = 4'h1; hwdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_hreadyout", {31'b0, be_hreadyout}, 32'd1);
    chk("rst_hresp",     {31'b0, be_hresp},     32'd0);
    chk("rst_hrdata",    be_hrdata,             32'h0);
    chk("rst_mem_valid", {31'b0, be_mem_valid}, 32'd0);
    chk("rst_mem_addr",  be_mem_addr,           32'h0);
    chk("rst_mem_wstrb", {28'b0, be_mem_wstrb}, 32'h0);
    chk("rst_mem_instr", {31'b0, be_mem_instr}, 32'd0);
    resetn = 1'b1;
    tick();

    // BE word read at 0x100
    addr_phase(32'h100, 1'b0, 3'd2, 4'h1);
    chk("rd_valid",   {31'b0, be_mem_valid}, 32'd1);
    chk("rd_addr",    be_mem_addr,           32'h100);
    chk("rd_wstrb",   {28'b0, be_mem_wstrb}, 32'h0);
    chk("rd_wait",    {31'b0, be_hreadyout}, 32'd0);
    chk("rd_instr",   {31'b0, be_mem_instr}, 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h44332211;
    tick();
    mem_ready = 1'b0;
    chk("rd_done",    {31'b0, be_hreadyout}, 32'd1);
    chk("rd_hrdata",  be_hrdata,             32'h11223344);
    chk("rd_le_hrdata", le_hrdata,           32'h44332211);
    chk("rd_valid_off", {31'b0, be_mem_valid}, 32'd0);

    // BE byte write at 0x203 as an instruction-side access; offset 3 sits on AHB lane [7:0]
    addr_phase(32'h203, 1'b1, 3'd0, 4'h0);
    hwdata = 32'h000000AB;
    #1;
    chk("bw_addr",    be_mem_addr,           32'h200);
    chk("bw_wstrb",   {28'b0, be_mem_wstrb}, 32'h8);
    chk("bw_wdata",   be_mem_wdata,          32'hAB000000);
    chk("bw_le_wdata", le_mem_wdata,         32'h000000AB);
    chk("bw_instr",   {31'b0, be_mem_instr}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("bw_done",    {31'b0, be_hreadyout}, 32'd1);
    chk("bw_hrdata_hold", be_hrdata,         32'h11223344);

    // Halfword write at 0x002
    addr_phase(32'h002, 1'b1, 3'd1, 4'h1);
    hwdata = 32'hBEEF0000;
    #1;
    chk("hw_le_wstrb", {28'b0, le_mem_wstrb}, 32'hC);
    chk("hw_le_wdata", le_mem_wdata,          32'hBEEF0000);
    chk("hw_be_wdata", be_mem_wdata,          32'h0000EFBE);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // Misaligned word read, then hsize=3 presented during ERR2
    addr_phase(32'h6, 1'b0, 3'd2, 4'h1);
    chk("e1_ready", {31'b0, be_hreadyout}, 32'd0);
    chk("e1_resp",  {31'b0, be_hresp},     32'd1);
    chk("e1_valid", {31'b0, be_mem_valid}, 32'd0);
    tick();
    chk("e2_ready", {31'b0, be_hreadyout}, 32'd1);
    chk("e2_resp",  {31'b0, be_hresp},     32'd1);
    addr_phase(32'h8, 1'b0, 3'd3, 4'h1);
    chk("e3_ready", {31'b0, be_hreadyout}, 32'd0);
    chk("e3_resp",  {31'b0, be_hresp},     32'd1);
    chk("e3_valid", {31'b0, be_mem_valid}, 32'd0);
    tick();
    chk("e4_ready", {31'b0, be_hreadyout}, 32'd1);
    chk("e4_resp",  {31'b0, be_hresp},     32'd1);
    chk("e4_valid", {31'b0, be_mem_valid}, 32'd0);
    tick();
    chk("e_idle_resp", {31'b0, be_hresp}, 32'd0);
    chk("e_hrdata_hold", be_hrdata,       32'h11223344);

    // Back-to-back writes, first held off three cycles
    addr_phase(32'h10, 1'b1, 3'd2, 4'h1);
    hwdata = 32'h12345678;
    #1;
    chk("bb1_wdata", be_mem_wdata, 32'h78563412);
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!be_hreadyout && be_mem_valid) low_cnt++;
      mem_ready = (i == 3);
      tick();
    end
    mem_ready = 1'b0;
    chk("bb1_low_cycles", low_cnt,         32'd4);
    chk("bb1_done",  {31'b0, be_hreadyout}, 32'd1);
    chk("bb1_valid_off", {31'b0, be_mem_valid}, 32'd0);
    addr_phase(32'h14, 1'b1, 3'd2, 4'h1);
    hwdata = 32'hCAFEF00D;
    #1;
    chk("bb2_valid", {31'b0, be_mem_valid}, 32'd1);
    chk("bb2_addr",  be_mem_addr,           32'h14);
    chk("bb2_wdata", be_mem_wdata,          32'h0DF0FECA);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("bb2_done",  {31'b0, be_hreadyout}, 32'd1);

    // Reset mid-access, then a normal read
    addr_phase(32'h20, 1'b0, 3'd2, 4'h1);
    chk("ra_valid", {31'b0, be_mem_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ra_valid_drop", {31'b0, be_mem_valid}, 32'd0);
    chk("ra_ready",      {31'b0, be_hreadyout}, 32'd1);
    chk("ra_hrdata",     be_hrdata,             32'h0);
    tick();
    resetn = 1'b1;
    tick();
    chk("ra_stay_idle", {31'b0, be_mem_valid}, 32'd0);
    addr_phase(32'h24, 1'b0, 3'd2, 4'h1);
    chk("rb_valid", {31'b0, be_mem_valid}, 32'd1);
    chk("rb_addr",  be_mem_addr,           32'h24);
    mem_ready = 1'b1; mem_rdata = 32'hA1B2C3D4;
    tick();
    mem_ready = 1'b0;
    chk("rb_done",   {31'b0, be_hreadyout}, 32'd1);
    chk("rb_hrdata", be_hrdata,             32'hD4C3B2A1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
